// File: rtl/dmem_responder_if.sv
// Request/response channel between a core memory stage and the data-memory responder.
// The core drives the request fields and rsp_ready; the responder drives the rest.
interface dmem_responder_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [AWIDTH-1:0] req_addr;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [DWIDTH-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DWIDTH-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one outstanding sized load/store at a time,
// committed LATENCY cycles after acceptance and answered over a valid/ready channel.
module dmem_responder #(
    parameter int                AWIDTH      = 32,
    parameter int                DWIDTH      = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR   = 32'h0200_0000,
    parameter int                DEPTH_WORDS = 1024,
    parameter int                LATENCY     = 2
) (
    input logic              clk,
    input logic              reset,
    dmem_responder_if.slave  bus
);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [AWIDTH:0] LO_BOUND = {1'b0, BASE_ADDR};
    localparam logic [AWIDTH:0] HI_BOUND = LO_BOUND + (AWIDTH+1)'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q;
    logic [AWIDTH-1:0] addr_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic [DWIDTH-1:0] wdata_q;
    logic [DWIDTH-1:0] rdata_q;
    logic              err_q;

    // Contents are never reset; they rely on the zero power-up value of the array.
    logic [31:0] mem [DEPTH_WORDS];

    logic [AWIDTH:0]   addr_ext, offset;
    logic              in_range, misaligned, access_err, commit;
    logic [IDX_W-1:0]  word_idx;
    logic [1:0]        lane;
    logic [31:0]       cur_word, new_word, wr_lanes, shifted, load_data;
    logic [3:0]        byte_en;
    logic              unused_offset_bits;

    assign addr_ext   = {1'b0, addr_q};
    assign offset     = addr_ext - LO_BOUND;
    assign in_range   = (addr_ext >= LO_BOUND) && (addr_ext < HI_BOUND);
    assign misaligned = ((size_q == 2'b01) && addr_q[0]) ||
                        ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
    assign access_err = (size_q == 2'b11) || misaligned || !in_range;
    assign word_idx   = offset[IDX_W+1:2];
    assign lane       = addr_q[1:0];
    assign cur_word   = mem[word_idx];
    assign commit     = (state_q == BUSY) && (cnt_q == 4'd0);
    assign unused_offset_bits = ^{offset[AWIDTH:IDX_W+2], offset[1:0]};

    // Store merge and load extraction both work on the addressed word read combinationally.
    always_comb begin
        byte_en   = 4'b0000;
        wr_lanes  = wdata_q;
        new_word  = cur_word;
        shifted   = cur_word >> {lane, 3'b000};
        load_data = cur_word;
        case (size_q)
            2'b00: begin
                byte_en[lane] = 1'b1;
                wr_lanes      = {4{wdata_q[7:0]}};
                load_data     = unsigned_q ? {24'd0, shifted[7:0]}
                                           : {{24{shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                byte_en   = lane[1] ? 4'b1100 : 4'b0011;
                wr_lanes  = {2{wdata_q[15:0]}};
                load_data = unsigned_q ? {16'd0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
            end
            2'b10:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) new_word[8*i +: 8] = wr_lanes[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req_valid) state_d = BUSY;
            BUSY:    if (cnt_q == 4'd0) state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = '0;
        bus.rsp_err   = 1'b0;
        case (state_q)
            IDLE: bus.req_ready = 1'b1;
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_rdata = rdata_q;
                bus.rsp_err   = err_q;
            end
            default: ;
        endcase
    end

    // Request capture, latency countdown and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state_q == IDLE && bus.req_valid) begin
                addr_q     <= bus.req_addr;
                we_q       <= bus.req_we;
                size_q     <= bus.req_size;
                unsigned_q <= bus.req_unsigned;
                wdata_q    <= bus.req_wdata;
                cnt_q      <= 4'(LATENCY - 1);
            end
            if (state_q == BUSY && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
            if (commit) begin
                err_q   <= access_err;
                rdata_q <= (access_err || we_q) ? '0 : load_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && commit && !access_err && we_q) mem[word_idx] <= new_word;
    end
endmodule
